// File: rtl/lot_occupancy_counter.sv
// lot_occupancy_counter: two-beam gate decoder feeding a saturating 0..CAPACITY car count.
// Define LOT_DEBOUNCE_EN to add a DEB_CYCLES stability filter after the synchronizers.
module lot_occupancy_counter #(
  parameter int CAPACITY   = 25,
  parameter int CNT_W      = 5,
  parameter int DEB_CYCLES = 16
) (
  input  logic             CLOCK_50,
  input  logic             RSTN,
  input  logic             sensA,
  input  logic             sensB,
  output logic [CNT_W-1:0] cntNum,
  output logic             enterPulse,
  output logic             exitPulse,
  output logic             full,
  output logic             empty
);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} state_t;
  state_t r_state, w_state_nxt;
  logic [1:0] r_sync1, r_sync2, w_ab;
  logic w_inc, w_dec, w_do_inc, w_do_dec;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic r_enter, r_exit, r_full, r_empty;
  always_ff @(posedge CLOCK_50 or negedge RSTN)
    if (!RSTN) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {sensA, sensB};
      r_sync2 <= r_sync1;
    end
`ifdef LOT_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic [1:0] r_flt;
  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic [DW-1:0] r_dcnt;
    always_ff @(posedge CLOCK_50 or negedge RSTN)
      if (!RSTN) begin
        r_dcnt   <= '0;
        r_flt[g] <= 1'b0;
      end else if (r_sync2[g] == r_flt[g]) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DW'(DEB_CYCLES - 1)) begin
        r_dcnt   <= '0;
        r_flt[g] <= r_sync2[g];
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
  end
  assign w_ab = r_flt;
`else
  assign w_ab = r_sync2;
`endif
  always_ff @(posedge CLOCK_50 or negedge RSTN)
    if (!RSTN) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  // w_ab is {a,b}: entry walks 10,11,01,00; exit walks 01,11,10,00
  always_comb begin
    w_state_nxt = IDLE;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = (w_ab == 2'b10) ? EN1 : (w_ab == 2'b01) ? EX1 : IDLE;
      EN1:  w_state_nxt = (w_ab == 2'b10) ? EN1 : (w_ab == 2'b11) ? EN2 : IDLE;
      EN2:  w_state_nxt = (w_ab == 2'b11) ? EN2 : (w_ab == 2'b01) ? EN3 :
                          (w_ab == 2'b10) ? EN1 : IDLE;
      EN3: begin
        w_state_nxt = (w_ab == 2'b01) ? EN3 : (w_ab == 2'b11) ? EN2 : IDLE;
        w_inc       = (w_ab == 2'b00);
      end
      EX1:  w_state_nxt = (w_ab == 2'b01) ? EX1 : (w_ab == 2'b11) ? EX2 : IDLE;
      EX2:  w_state_nxt = (w_ab == 2'b11) ? EX2 : (w_ab == 2'b10) ? EX3 :
                          (w_ab == 2'b01) ? EX1 : IDLE;
      EX3: begin
        w_state_nxt = (w_ab == 2'b10) ? EX3 : (w_ab == 2'b11) ? EX2 : IDLE;
        w_dec       = (w_ab == 2'b00);
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  assign w_do_inc  = w_inc && (r_cnt != CAP);
  assign w_do_dec  = w_dec && (r_cnt != '0);
  assign w_cnt_nxt = w_do_inc ? r_cnt + 1'b1 : w_do_dec ? r_cnt - 1'b1 : r_cnt;
  always_ff @(posedge CLOCK_50 or negedge RSTN)
    if (!RSTN) begin
      r_cnt   <= '0;
      r_enter <= 1'b0;
      r_exit  <= 1'b0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_enter <= w_do_inc;
      r_exit  <= w_do_dec;
      r_full  <= (w_cnt_nxt == CAP);
      r_empty <= (w_cnt_nxt == '0);
    end
  assign cntNum     = r_cnt;
  assign enterPulse = r_enter;
  assign exitPulse  = r_exit;
  assign full       = r_full;
  assign empty      = r_empty;
endmodule

// File: tb/tb_lot_occupancy_counter.sv
// tb_lot_occupancy_counter: directed vector table plus hand-written latency, saturation and reset sequences.
module tb_lot_occupancy_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sens_a = 1'b0, sens_b = 1'b0;
  logic [4:0] cnt;
  logic enter_p, exit_p, full_f, empty_f;
  int checks = 0, fails = 0;
  int n_en = 0, n_ex = 0;
  lot_occupancy_counter dut (
    .CLOCK_50(clk), .RSTN(rst_n), .sensA(sens_a), .sensB(sens_b),
    .cntNum(cnt), .enterPulse(enter_p), .exitPulse(exit_p), .full(full_f), .empty(empty_f)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (enter_p) n_en++;
    if (exit_p) n_ex++;
  end
  typedef struct {
    logic [11:0] ph;
    int n;
    int cnt;
    int en;
    int ex;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] ab, input int n);
    {sens_a, sens_b} = ab;
    repeat (n) @(negedge clk);
  endtask
  task automatic run_seq(input logic [11:0] ph, input int n);
    for (int i = 0; i < n; i++) drive(ph[11-2*i -: 2], 4);
  endtask
  task automatic check_state(input string tag, input int c);
    chk({tag, " cnt"}, int'(cnt), c);
    chk({tag, " full"}, int'(full_f), int'(c == 25));
    chk({tag, " empty"}, int'(empty_f), int'(c == 0));
  endtask
  initial begin
    int e0, x0, base;
    vecs[0] = '{12'b10_11_01_00_00_00, 4, 1, 1, 0};
    vecs[1] = '{12'b10_11_10_00_00_00, 4, 1, 0, 0};
    vecs[2] = '{12'b10_11_01_11_01_00, 6, 2, 1, 0};
    vecs[3] = '{12'b01_11_10_00_00_00, 4, 1, 0, 1};
    vecs[4] = '{12'b11_00_00_00_00_00, 2, 1, 0, 0};
    vecs[5] = '{12'b01_11_10_00_00_00, 4, 0, 0, 1};
    vecs[6] = '{12'b01_11_10_00_00_00, 4, 0, 0, 0};
    vecs[7] = '{12'b10_00_00_00_00_00, 2, 0, 0, 0};
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_state("reset", 0);
    chk("reset pulses", n_en + n_ex, 0);
    for (int v = 0; v < 8; v++) begin
      e0 = n_en;
      x0 = n_ex;
      run_seq(vecs[v].ph, vecs[v].n);
      check_state($sformatf("vec%0d", v), vecs[v].cnt);
      chk($sformatf("vec%0d enter", v), n_en - e0, vecs[v].en);
      chk($sformatf("vec%0d exit", v), n_ex - x0, vecs[v].ex);
    end
    run_seq(12'b10_11_01_00_00_00, 3);
    {sens_a, sens_b} = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("lat edge2 cnt", int'(cnt), 0);
    chk("lat edge2 pulse", int'(enter_p), 0);
    @(negedge clk);
    chk("lat edge3 cnt", int'(cnt), 1);
    chk("lat edge3 pulse", int'(enter_p), 1);
    chk("lat edge3 empty", int'(empty_f), 0);
    @(negedge clk);
    chk("lat pulse width", int'(enter_p), 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 24; i++) run_seq(12'b10_11_01_00_00_00, 4);
    check_state("sat25", 25);
    e0 = n_en;
    run_seq(12'b10_11_01_00_00_00, 4);
    check_state("sat26", 25);
    chk("sat26 enter", n_en - e0, 0);
    x0 = n_ex;
    run_seq(12'b01_11_10_00_00_00, 4);
    check_state("sat exit", 24);
    chk("sat exit pulse", n_ex - x0, 1);
    base = n_en + n_ex;
    run_seq(12'b10_11_00_00_00_00, 2);
    rst_n = 1'b0;
    #1;
    chk("async rst cnt", int'(cnt), 0);
    repeat (3) @(negedge clk);
    check_state("mid rst", 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_seq(12'b01_00_00_00_00_00, 2);
    check_state("post rst", 0);
    chk("post rst pulses", n_en + n_ex - base, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
